mux4_rr_arbiter: RTL

//  Round-robin arbiter that shares one 4:1 mux datapath among four requesters.

---
 rtl/mux4_rr_arbiter.sv | 90 +++++++++
 1 files changed

// File: rtl/mux4_rr_arbiter.sv
// Round-robin owner for one shared 4:1 mux, with a break-before-make gap between owners and a hold-limit preempt.
// Latency: req to gnt/s1s0 is 1 cycle; each owner change inserts one zero-grant GAP cycle.
module mux4_rr_arbiter #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic       s0,
    output logic       s1,
    output logic       sel_valid,
    output logic       preempt
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;
    localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);

    logic [1:0] state;
    logic [7:0] hold_cnt;
    logic [1:0] last;
    logic [1:0] winner;
    logic [1:0] idx;
    logic       any_req;

    // Scan from last+4 down to last+1 so the lowest offset above last wins.
    always_comb begin
        winner  = last;
        idx     = last;
        any_req = |req;
        for (int i = 4; i >= 1; i--) begin
            idx = last + 2'(i);
            if (req[idx]) begin
                winner = idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            gnt       <= 4'b0000;
            s1        <= 1'b0;
            s0        <= 1'b0;
            sel_valid <= 1'b0;
            preempt   <= 1'b0;
            hold_cnt  <= 8'd0;
            last      <= 2'd3;
        end else begin
            case (state)
                ST_GRANT: begin
                    // While granted, last is the current owner.
                    if (req[last] && (hold_cnt < HOLD_LIM)) begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end else begin
                        state     <= ST_GAP;
                        gnt       <= 4'b0000;
                        sel_valid <= 1'b0;
                        preempt   <= req[last];
                        hold_cnt  <= 8'd0;
                    end
                end
                ST_IDLE, ST_GAP: begin
                    preempt <= 1'b0;
                    if (any_req) begin
                        state     <= ST_GRANT;
                        gnt       <= 4'b0001 << winner;
                        s1        <= winner[1];
                        s0        <= winner[0];
                        sel_valid <= 1'b1;
                        hold_cnt  <= 8'd1;
                        last      <= winner;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    gnt       <= 4'b0000;
                    sel_valid <= 1'b0;
                    preempt   <= 1'b0;
                    hold_cnt  <= 8'd0;
                end
            endcase
        end
    end

endmodule
